// File: rtl/cpu_axi_pkg.sv
// -----------------------------------------------------------------------------
// cpu_axi_pkg
// Shared AXI encodings and CPU-side constants for the instruction-fetch path.
//   - AXI burst, size and response encodings
//   - INSN_NOP: the instruction returned to the fetch stage when an access fails
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_axi_pkg;

  // AXI burst types
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // AXI transfer size: bytes per beat = 2**size
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  // AXI response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Single-beat read
  localparam logic [7:0] AXI_LEN_1 = 8'd0;

  // RV32I canonical NOP: addi x0, x0, 0
  localparam logic [31:0] INSN_NOP = 32'h0000_0013;

endpackage

// File: rtl/im_fetch_bridge_if.sv
// -----------------------------------------------------------------------------
// im_fetch_bridge_if
// Bundles the fetch-stage request/response signals and the AXI AR/R channels
// seen by the instruction-fetch bridge.
//   Parameter ID_W : width of arid/rid.
//   Fetch side : fetch_addr, fetch_req_valid, fetch_req_ready,
//                fetch_data, fetch_data_valid, fetch_err
//   AXI AR     : araddr, arid, arlen, arsize, arburst, arvalid, arready
//   AXI R      : rdata, rid, rresp, rlast, rvalid, rready
// Modports:
//   master : the bridge (drives fetch responses and AXI requests)
//   slave  : the environment (fetch stage + AXI memory)
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready are high. Once a source raises valid it keeps valid and its
// payload stable until the transfer. fetch_data_valid is a one-cycle pulse with
// no ready; the consumer must take it in that cycle.
// -----------------------------------------------------------------------------
interface im_fetch_bridge_if #(
  parameter int ID_W = 4
) ();

  // Fetch stage side
  logic [31:0]     fetch_addr;
  logic            fetch_req_valid;
  logic            fetch_req_ready;
  logic [31:0]     fetch_data;
  logic            fetch_data_valid;
  logic            fetch_err;

  // AXI read address channel
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  // AXI read data channel
  logic [31:0]     rdata;
  logic [ID_W-1:0] rid;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    input  fetch_addr, fetch_req_valid,
    output fetch_req_ready, fetch_data, fetch_data_valid, fetch_err,
    output araddr, arid, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rid, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output fetch_addr, fetch_req_valid,
    input  fetch_req_ready, fetch_data, fetch_data_valid, fetch_err,
    input  araddr, arid, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rid, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/im_fetch_bridge.sv
// -----------------------------------------------------------------------------
// im_fetch_bridge
// Converts single instruction-fetch requests into single-beat AXI reads.
// One request is outstanding at a time; every accepted request produces
// exactly one fetch_data_valid pulse. Failed accesses (bad response, wrong ID,
// missing rlast, or misaligned fetch address) return a NOP with fetch_err set.
//
// Parameters:
//   ID_W     : width of arid/rid
//   ARID_VAL : constant AXI read ID driven on every request
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : im_fetch_bridge_if.master (fetch side + AXI AR/R)
//   dbg_state_o : current FSM state (0=IDLE, 1=AR, 2=R, 3=RESP)
// -----------------------------------------------------------------------------
module im_fetch_bridge
  import cpu_axi_pkg::*;
#(
  parameter int              ID_W     = 4,
  // Zero in the declared ID width (4'h0 at the default width)
  parameter logic [ID_W-1:0] ARID_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  im_fetch_bridge_if.master   bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] data_q,  data_d;
  logic        err_q,   err_d;
  logic        rsp_err;

  // A misaligned address is still sent to memory (word-aligned) so the AXI
  // transaction always completes; the misalignment only poisons the result.
  assign rsp_err = (bus.rresp != AXI_RESP_OKAY)
                || (bus.rid   != ARID_VAL)
                || !bus.rlast
                || (addr_q[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.fetch_req_valid) begin
          addr_d  = bus.fetch_addr;
          state_d = ST_AR;
        end
      end
      ST_AR: begin
        if (bus.arready) state_d = ST_R;
      end
      ST_R: begin
        if (bus.rvalid) begin
          data_d  = rsp_err ? INSN_NOP : bus.rdata;
          err_d   = rsp_err;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All handshake outputs are decoded from the state register alone, so the
  // AR payload is stable for as long as arvalid is held.
  assign bus.fetch_req_ready  = (state_q == ST_IDLE);
  assign bus.arvalid          = (state_q == ST_AR);
  assign bus.rready           = (state_q == ST_R);
  assign bus.fetch_data_valid = (state_q == ST_RESP);
  assign bus.fetch_err        = (state_q == ST_RESP) && err_q;
  assign bus.fetch_data       = data_q;

  assign bus.araddr  = {addr_q[31:2], 2'b00};
  assign bus.arid    = ARID_VAL;
  assign bus.arlen   = AXI_LEN_1;
  assign bus.arsize  = AXI_SIZE_4B;
  assign bus.arburst = AXI_BURST_INCR;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_im_fetch_bridge.sv
module tb_im_fetch_bridge;

  localparam int              ID_W = 4;
  localparam logic [ID_W-1:0] ARID = 4'h3;
  localparam logic [31:0]     NOP  = 32'h0000_0013;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  im_fetch_bridge_if #(.ID_W(ID_W)) bus ();

  im_fetch_bridge #(
    .ID_W     (ID_W),
    .ARID_VAL (ARID)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int          pulse_cnt = 0;
  logic [31:0] last_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fetch_err && !bus.fetch_data_valid)
        check("err_without_valid", {63'd0, bus.fetch_err}, 64'd0);
      if (bus.fetch_data_valid) begin
        pulse_cnt++;
        last_data = bus.fetch_data;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {63'd0, bus.fetch_data_valid}, 64'd0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("fetch_rsp", {31'd0, bus.fetch_err, bus.fetch_data}, {31'd0, e});
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one fetch, plays the AXI memory, and returns once the response
  // cycle has been reached. Called and returns at a falling edge.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] rd,
                          input logic [1:0] resp, input logic [ID_W-1:0] id,
                          input logic last, input int ar_stall, input int r_stall,
                          output int lat, output int waited);
    int          t0;
    logic        exp_err;
    logic [31:0] exp_araddr;
    bus.rvalid          = 1'b0;
    bus.arready         = 1'b0;
    bus.fetch_addr      = addr;
    bus.fetch_req_valid = 1'b1;
    waited = 0;
    while (!bus.fetch_req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready", {63'd0, bus.fetch_req_ready}, 64'd1);
    exp_err    = (resp != 2'b00) || (id != ARID) || !last || (addr[1:0] != 2'b00);
    exp_araddr = addr & 32'hFFFF_FFFC;
    exp_q.push_back({exp_err, exp_err ? NOP : rd});
    t0 = cyc;
    @(negedge clk);
    bus.fetch_req_valid = 1'b0;
    bus.fetch_addr      = $urandom();
    check("arvalid", {63'd0, bus.arvalid}, 64'd1);
    check("araddr", {32'd0, bus.araddr}, {32'd0, exp_araddr});
    check("ar_attr", {49'd0, bus.arid, bus.arlen, bus.arsize, bus.arburst},
          {49'd0, ARID, 8'd0, 3'b010, 2'b01});
    check("ready_busy", {63'd0, bus.fetch_req_ready}, 64'd0);
    for (int i = 0; i < ar_stall; i++) begin
      // stray R beats while the address is still pending must be ignored
      bus.rvalid = 1'b1;
      bus.rdata  = $urandom();
      bus.rresp  = 2'b00;
      bus.rid    = ARID;
      bus.rlast  = 1'b1;
      check("ar_stall_valid", {63'd0, bus.arvalid}, 64'd1);
      check("ar_stall_addr", {32'd0, bus.araddr}, {32'd0, exp_araddr});
      check("rready_in_ar", {63'd0, bus.rready}, 64'd0);
      @(negedge clk);
    end
    bus.rvalid  = 1'b0;
    bus.arready = 1'b1;
    check("arvalid_at_hs", {63'd0, bus.arvalid}, 64'd1);
    @(negedge clk);
    bus.arready = 1'b0;
    check("arvalid_drop", {63'd0, bus.arvalid}, 64'd0);
    for (int i = 0; i < r_stall; i++) begin
      check("rready_wait", {63'd0, bus.rready}, 64'd1);
      @(negedge clk);
    end
    check("rready", {63'd0, bus.rready}, 64'd1);
    bus.rvalid = 1'b1;
    bus.rdata  = rd;
    bus.rresp  = resp;
    bus.rid    = id;
    bus.rlast  = last;
    @(negedge clk);
    bus.rvalid = 1'b0;
    bus.rdata  = $urandom();
    check("data_valid", {63'd0, bus.fetch_data_valid}, 64'd1);
    lat = cyc - t0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int waited;
    int pulses_before;
    bus.fetch_addr      = '0;
    bus.fetch_req_valid = 1'b0;
    bus.arready         = 1'b0;
    bus.rdata           = '0;
    bus.rid             = '0;
    bus.rresp           = '0;
    bus.rlast           = 1'b0;
    bus.rvalid          = 1'b0;
    rst_n               = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_arvalid", {63'd0, bus.arvalid}, 64'd0);
    check("rst_rready", {63'd0, bus.rready}, 64'd0);
    check("rst_dv_err", {62'd0, bus.fetch_data_valid, bus.fetch_err}, 64'd0);
    check("rst_data", {32'd0, bus.fetch_data}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    check("rst_araddr", {32'd0, bus.araddr}, 64'd0);

    // zero-wait fetch, accepted on the first edge after reset release
    rst_n = 1'b1;
    do_fetch(32'h0000_0100, 32'h0010_0093, 2'b00, ARID, 1'b1, 0, 0, lat, waited);
    check("first_accept_wait", 64'(waited), 64'd0);
    check("zero_wait_lat", 64'(lat), 64'd3);
    @(negedge clk);
    check("data_hold", {32'd0, bus.fetch_data}, {32'd0, last_data});

    // AR stall for 5 cycles
    do_fetch(32'h0000_0100, 32'h0020_0113, 2'b00, ARID, 1'b1, 5, 0, lat, waited);
    check("ar_stall_lat", 64'(lat), 64'd8);

    // SLVERR
    do_fetch(32'h0000_0200, 32'hDEAD_BEEF, 2'b10, ARID, 1'b1, 0, 2, lat, waited);
    @(negedge clk);
    check("slverr_err_one_cycle", {63'd0, bus.fetch_err}, 64'd0);
    check("slverr_idle", {62'd0, dbg_state}, 64'd0);

    // misaligned, wrong ID, missing rlast
    do_fetch(32'h0000_0102, 32'h1234_5678, 2'b00, ARID, 1'b1, 1, 0, lat, waited);
    do_fetch(32'h0000_0300, 32'h1111_2222, 2'b00, ARID ^ 4'h1, 1'b1, 0, 0, lat, waited);
    do_fetch(32'h0000_0304, 32'h3333_4444, 2'b00, ARID, 1'b0, 0, 0, lat, waited);
    @(negedge clk);

    // back-to-back
    for (int i = 0; i < 3; i++) begin
      do_fetch(32'(i * 4), 32'h0000_1000 + 32'(i), 2'b00, ARID, 1'b1, 0, 0, lat, waited);
      @(negedge clk);
      check("b2b_ready", {63'd0, bus.fetch_req_ready}, 64'd1);
    end

    // reset while in R
    bus.fetch_addr      = 32'h0000_0400;
    bus.fetch_req_valid = 1'b1;
    @(negedge clk);
    bus.fetch_req_valid = 1'b0;
    bus.arready         = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    check("pre_rst_rready", {63'd0, bus.rready}, 64'd1);
    pulses_before = pulse_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ar_r", {62'd0, bus.arvalid, bus.rready}, 64'd0);
    check("mid_rst_dv", {63'd0, bus.fetch_data_valid}, 64'd0);
    check("mid_rst_state", {62'd0, dbg_state}, 64'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'hBAD0_BAD0;
    bus.rresp   = 2'b00;
    bus.rid     = ARID;
    bus.rlast   = 1'b1;
    repeat (5) @(negedge clk);
    bus.rvalid = 1'b0;
    check("no_pulse_after_rst", 64'(pulse_cnt - pulses_before), 64'd0);
    do_fetch(32'h0000_0500, 32'h0050_0293, 2'b00, ARID, 1'b1, 0, 0, lat, waited);
    check("post_rst_lat", 64'(lat), 64'd3);

    // random traffic
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      logic [1:0]  r;
      a = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      r = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_fetch(a, $urandom(), r, ARID, 1'b1,
               $urandom_range(0, 3), $urandom_range(0, 3), lat, waited);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/im_fetch_bridge.md
IM_FETCH_BRIDGE -- requirements
Module: im_fetch_bridge

Interface
REQ-001 The block SHALL have parameter ARID_VAL, default 4'h0, the constant AXI read ID driven on every request.
REQ-002 The block SHALL have parameter ID_W, default 4, the width of arid/rid.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 fetch_addr  in  32  fetch byte address from the fetch stage.
REQ-006 fetch_req_valid  in  1  fetch request present.
REQ-007 fetch_req_ready  out  1  request accepted when valid && ready.
REQ-008 fetch_data  out  32  returned instruction word.
REQ-009 fetch_data_valid  out  1  one-cycle pulse qualifying fetch_data; no backpressure.
REQ-010 fetch_err  out  1  one-cycle pulse coincident with fetch_data_valid when the access failed.
REQ-011 araddr  out  32  AXI read address; arid ID_W out; arlen 8 out (8'd0); arsize 3 out (3'b010); arburst 2 out (INCR).
REQ-012 arvalid  out  1  and  arready  in  1  AXI AR handshake.
REQ-013 rdata  in  32; rid  in  ID_W; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1  AXI R channel.

Function
REQ-014 FSM states SHALL be IDLE, AR, R, RESP.
REQ-015 IDLE: fetch_req_ready=1; on fetch handshake latch fetch_addr and go to AR; otherwise stay.
REQ-016 AR: arvalid=1 with araddr = latched address, bits [1:0] forced to 2'b00; on arready go to R.
REQ-017 araddr/arvalid SHALL stay stable while arvalid=1 and arready=0.
REQ-018 R: rready=1; on rvalid register rdata, rid, rresp and go to RESP.
REQ-019 RESP: fetch_data_valid=1 for exactly one cycle, then unconditionally return to IDLE.
REQ-020 fetch_req_ready SHALL be 0 in AR, R and RESP; at most one outstanding request.
REQ-021 Minimum latency: request handshake at cycle N, arvalid at N+1, data valid at N+3 when arready and rvalid are both high on first assertion.
REQ-022 Error condition = rresp != OKAY, or rid != ARID_VAL, or rlast == 0, or latched fetch_addr[1:0] != 0.
REQ-023 On error, fetch_data SHALL be 32'h0000_0013 (NOP) and fetch_err=1 for the RESP cycle; the AXI transaction SHALL still be issued and completed for a misaligned address.
REQ-024 Exactly one fetch_data_valid pulse SHALL be produced per accepted request; no request is ever abandoned mid-transaction.
REQ-025 rvalid arriving in IDLE or AR SHALL be ignored (rready=0 there).
REQ-026 fetch_data SHALL hold its last value outside RESP; consumers qualify it only with fetch_data_valid.

Reset
REQ-027 While rst_n=0: state=IDLE, arvalid=0, rready=0, fetch_data_valid=0, fetch_err=0, fetch_data=0, latched address=0.
REQ-028 Reset asserted mid-transaction SHALL abort immediately; no response pulse after release.
REQ-029 The first request SHALL be accepted on the first clock edge after rst_n deasserts.

Structure
REQ-030 AXI burst/size/resp encodings and the NOP constant SHALL live in a shared package (cpu_axi_pkg); the FSM state typedef SHALL be local to the module.
REQ-031 The block SHALL be a single module with no sub-modules.

Verification
REQ-032 Zero wait: request 0x0000_0100, arready=1, rvalid=1 with rdata=0x0010_0093, OKAY -> data valid at N+3 with 0x0010_0093, fetch_err=0.
REQ-033 AR stall: arready held low 5 cycles -> araddr stable at 0x100 all 5 cycles; data valid 5 cycles later than REQ-032.
REQ-034 SLVERR: rresp=2'b10 -> fetch_data=0x0000_0013, fetch_err=1 for one cycle, state back to IDLE.
REQ-035 Misaligned 0x0000_0102 -> araddr=0x0000_0100, fetch_err=1, NOP returned.
REQ-036 Back-to-back: requests 0x0, 0x4, 0x8 issued as soon as ready -> three data pulses, in order, each followed by fetch_req_ready=1 the next cycle.
REQ-037 Reset during R state -> arvalid=rready=0 immediately; no fetch_data_valid after release until a new request completes.
